// File: rtl/fetch_unit.sv
// Instruction-fetch stage: sequential PC generation, credit-limited memory requests,
// a two-entry instruction buffer for the IF/ID register, and epoch-based redirect flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr_out,
  output logic [31:0] pc_prev_address,
  output logic        instr_valid
);

  localparam logic [2:0] CREDITS = 3'(DEPTH);

  logic [31:0] pc_q, pc_d;
  logic        epoch_q, epoch_d;
  logic [1:0]  outst_q, outst_d;

  // Tag FIFO: one {epoch, pc} entry per accepted request, popped by each response.
  logic        tag_epoch_q [2];
  logic [31:0] tag_pc_q [2];
  logic        tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  logic [31:0] buf_instr_q [2];
  logic [31:0] buf_pc_q [2];
  logic        buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  logic [1:0]  buf_cnt_q, buf_cnt_d;

  logic credit_ok, req_fire, rsp_keep, pop;

  // Handshake: a request transfers on a clock edge where imem_req_valid && imem_req_ready.
  // Valid is withheld during a redirect cycle, so the address never moves under a pending request.
  assign credit_ok       = ({1'b0, outst_q} + {1'b0, buf_cnt_q}) < CREDITS;
  assign imem_req_valid  = !rst && !redirect_valid && credit_ok;
  assign imem_req_addr   = pc_q;
  assign req_fire        = imem_req_valid && imem_req_ready;

  assign rsp_keep        = imem_rsp_valid && !redirect_valid &&
                           (tag_epoch_q[tag_rd_q] == epoch_q);
  assign instr_valid     = (buf_cnt_q != 2'd0);
  assign instr_out       = instr_valid ? buf_instr_q[buf_rd_q] : 32'h0;
  assign pc_prev_address = instr_valid ? buf_pc_q[buf_rd_q] : 32'h0;
  assign pop             = instr_valid && !stall && !redirect_valid;

  always_comb begin
    pc_d      = pc_q;
    epoch_d   = epoch_q;
    outst_d   = outst_q + {1'b0, req_fire} - {1'b0, imem_rsp_valid};
    tag_wr_d  = tag_wr_q ^ req_fire;
    tag_rd_d  = tag_rd_q ^ imem_rsp_valid;
    buf_wr_d  = buf_wr_q ^ rsp_keep;
    buf_rd_d  = buf_rd_q ^ pop;
    buf_cnt_d = buf_cnt_q + {1'b0, rsp_keep} - {1'b0, pop};
    if (req_fire) pc_d = pc_q + 32'd4;
    // Outstanding requests keep their credit; their stale responses are filtered by epoch.
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      epoch_d   = !epoch_q;
      buf_wr_d  = 1'b0;
      buf_rd_d  = 1'b0;
      buf_cnt_d = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      epoch_q        <= 1'b0;
      outst_q        <= 2'd0;
      tag_wr_q       <= 1'b0;
      tag_rd_q       <= 1'b0;
      buf_wr_q       <= 1'b0;
      buf_rd_q       <= 1'b0;
      buf_cnt_q      <= 2'd0;
      tag_epoch_q[0] <= 1'b0;
      tag_epoch_q[1] <= 1'b0;
      tag_pc_q[0]    <= 32'h0;
      tag_pc_q[1]    <= 32'h0;
      buf_instr_q[0] <= 32'h0;
      buf_instr_q[1] <= 32'h0;
      buf_pc_q[0]    <= 32'h0;
      buf_pc_q[1]    <= 32'h0;
    end else begin
      pc_q      <= pc_d;
      epoch_q   <= epoch_d;
      outst_q   <= outst_d;
      tag_wr_q  <= tag_wr_d;
      tag_rd_q  <= tag_rd_d;
      buf_wr_q  <= buf_wr_d;
      buf_rd_q  <= buf_rd_d;
      buf_cnt_q <= buf_cnt_d;
      if (req_fire) begin
        tag_epoch_q[tag_wr_q] <= epoch_q;
        tag_pc_q[tag_wr_q]    <= pc_q;
      end
      if (rsp_keep) begin
        buf_instr_q[buf_wr_q] <= imem_rsp_data;
        buf_pc_q[buf_wr_q]    <= tag_pc_q[tag_rd_q];
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order memory model with 1..3 cycle latency
// returns ~addr as the instruction word; consumed outputs are logged and compared in order.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic [31:0] instr_out;
  logic [31:0] pc_prev_address;
  logic        instr_valid;

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;

  logic [31:0] exp_q[$];
  logic [31:0] got_pc_q[$];
  logic [31:0] got_ins_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_out       (instr_out),
    .pc_prev_address (pc_prev_address),
    .instr_valid     (instr_valid)
  );

  always #5 clk = ~clk;

  // Memory model: handshake seen at negedge, response appears mem_lat cycles later.
  logic        hs_s, clr_s;
  logic [31:0] ha_s;
  logic        d_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] d_a [3] = '{32'h0, 32'h0, 32'h0};

  always begin
    @(negedge clk);
    hs_s  = imem_req_valid && imem_req_ready;
    ha_s  = imem_req_addr;
    clr_s = rst;
    @(posedge clk);
    #1;
    d_v[2] = d_v[1]; d_a[2] = d_a[1];
    d_v[1] = d_v[0]; d_a[1] = d_a[0];
    d_v[0] = hs_s;   d_a[0] = ha_s;
    if (clr_s) begin
      d_v[0] = 1'b0; d_v[1] = 1'b0; d_v[2] = 1'b0;
    end
    imem_rsp_valid = d_v[mem_lat-1];
    imem_rsp_data  = ~d_a[mem_lat-1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    if (instr_valid && !stall && !redirect_valid) begin
      got_pc_q.push_back(pc_prev_address);
      got_ins_q.push_back(instr_out);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      sample();
      tick();
    end
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, got_pc_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < got_pc_q.size()) begin
        chk({tag, "_pc"}, got_pc_q[i], exp_q[i]);
        chk({tag, "_instr"}, got_ins_q[i], ~exp_q[i]);
      end
    end
    exp_q.delete();
    got_pc_q.delete();
    got_ins_q.delete();
  endtask

  // Leaves the bench at the start of cycle 0 (first cycle out of reset).
  task automatic do_reset(input int lat);
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    mem_lat        = lat;
    @(negedge clk);
    chk1("rst_instr_valid", instr_valid, 1'b0);
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_instr_out", instr_out, 32'h0);
    chk("rst_pc_prev", pc_prev_address, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    got_pc_q.delete();
    got_ins_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // Sequential fetch and stall hold
    do_reset(1);
    sample();
    chk1("c0_req_valid", imem_req_valid, 1'b1);
    chk("c0_req_addr", imem_req_addr, 32'h0);
    chk1("c0_instr_valid", instr_valid, 1'b0);
    tick();
    sample();
    chk1("c1_req_valid", imem_req_valid, 1'b1);
    chk("c1_req_addr", imem_req_addr, 32'h4);
    chk1("c1_instr_valid", instr_valid, 1'b0);
    tick();
    sample();
    chk1("c2_instr_valid", instr_valid, 1'b1);
    chk("c2_pc", pc_prev_address, 32'h0);
    chk("c2_instr", instr_out, 32'hFFFF_FFFF);
    chk1("c2_no_credit", imem_req_valid, 1'b0);
    tick();
    step(2);
    stall = 1'b1;
    sample();
    chk1("stall_start_valid", instr_valid, 1'b1);
    chk("stall_start_pc", pc_prev_address, 32'h8);
    tick();
    step(1);
    sample();
    chk("stall_hold_pc", pc_prev_address, 32'h8);
    chk("stall_hold_instr", instr_out, ~32'h8);
    chk1("stall_credit_full", imem_req_valid, 1'b0);
    tick();
    stall = 1'b0;
    step(4);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    check_log("seq_order");

    // Redirect with two requests in flight (3-cycle memory)
    do_reset(3);
    sample();
    chk("lat3_c0_addr", imem_req_addr, 32'h0);
    tick();
    sample();
    chk1("lat3_c1_valid", imem_req_valid, 1'b1);
    chk("lat3_c1_addr", imem_req_addr, 32'h4);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    sample();
    chk1("redir_req_valid", imem_req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    sample();
    chk1("redir_n1_instr_valid", instr_valid, 1'b0);
    chk1("redir_n1_no_credit", imem_req_valid, 1'b0);
    tick();
    sample();
    chk1("redir_n2_req_valid", imem_req_valid, 1'b1);
    chk("redir_n2_req_addr", imem_req_addr, 32'h100);
    tick();
    step(2);
    sample();
    chk1("stale_dropped", instr_valid, 1'b0);
    tick();
    step(2);
    exp_q = '{32'h100, 32'h104};
    check_log("redir_order");

    // Redirect and stall together (1-cycle memory)
    do_reset(1);
    step(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    stall          = 1'b1;
    sample();
    tick();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    sample();
    chk1("rs_n1_req_valid", imem_req_valid, 1'b1);
    chk("rs_n1_req_addr", imem_req_addr, 32'h100);
    chk1("rs_n1_flushed", instr_valid, 1'b0);
    tick();
    sample();
    chk1("rs_n2_instr_valid", instr_valid, 1'b0);
    chk("rs_n2_req_addr", imem_req_addr, 32'h104);
    tick();
    sample();
    chk1("rs_n3_instr_valid", instr_valid, 1'b1);
    chk("rs_n3_pc", pc_prev_address, 32'h100);
    chk("rs_n3_instr", instr_out, ~32'h100);
    tick();
    step(1);
    exp_q = '{32'h100, 32'h104};
    check_log("rs_order");

    // Memory not ready for five cycles
    do_reset(1);
    step(3);
    imem_req_ready = 1'b0;
    sample();
    chk1("nr_c3_valid", imem_req_valid, 1'b1);
    chk("nr_c3_addr", imem_req_addr, 32'h8);
    tick();
    sample();
    chk1("nr_c4_drained", instr_valid, 1'b0);
    chk("nr_c4_addr", imem_req_addr, 32'h8);
    tick();
    step(2);
    sample();
    chk1("nr_c7_valid", imem_req_valid, 1'b1);
    chk("nr_c7_addr", imem_req_addr, 32'h8);
    chk1("nr_c7_drained", instr_valid, 1'b0);
    tick();
    imem_req_ready = 1'b1;
    sample();
    chk("nr_c8_addr", imem_req_addr, 32'h8);
    tick();
    sample();
    chk1("nr_c9_instr_valid", instr_valid, 1'b0);
    tick();
    sample();
    chk1("nr_c10_instr_valid", instr_valid, 1'b1);
    chk("nr_c10_pc", pc_prev_address, 32'h8);
    tick();
    exp_q = '{32'h0, 32'h4, 32'h8};
    check_log("nr_order");

    // Back-to-back redirects, last target at the top of the address space
    do_reset(1);
    step(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    sample();
    tick();
    redirect_pc = 32'hFFFF_FFFC;
    sample();
    chk1("b2b_req_valid", imem_req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    sample();
    chk1("b2b_n1_valid", imem_req_valid, 1'b1);
    chk("b2b_n1_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    sample();
    chk("wrap_addr", imem_req_addr, 32'h0);
    tick();
    step(2);
    exp_q = '{32'hFFFF_FFFC, 32'h0};
    check_log("wrap_order");

    // Asynchronous reset pulse mid-stream
    do_reset(1);
    step(3);
    #2;
    rst = 1'b1;
    #1;
    chk1("arst_instr_valid", instr_valid, 1'b0);
    chk("arst_instr_out", instr_out, 32'h0);
    chk("arst_pc_prev", pc_prev_address, 32'h0);
    chk1("arst_req_valid", imem_req_valid, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    sample();
    chk1("arst_c0_req_valid", imem_req_valid, 1'b1);
    chk("arst_c0_addr", imem_req_addr, 32'h0);
    chk1("arst_c0_instr_valid", instr_valid, 1'b0);
    tick();
    step(1);
    sample();
    chk1("arst_c2_instr_valid", instr_valid, 1'b1);
    chk("arst_c2_pc", pc_prev_address, 32'h0);
    chk("arst_c2_instr", instr_out, 32'hFFFF_FFFF);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
